// File: rtl/stage_control.sv
// stage_control: per-instruction stage enable mask, illegal-opcode flag,
// stage-sequence checker and retired-instruction accounting for a
// six-stage RV32I sequencer.
module stage_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stage_active,
  input  logic [6:0]  opcode,
  output logic [5:0]  stage_enabled,
  output logic        illegal_insn,
  output logic        seq_error,
  output logic [31:0] instret,
  output logic [2:0]  last_len
);

  // stage bit positions
  localparam int FETCH      = 0;
  localparam int DECODE     = 1;
  localparam int READ       = 2;
  localparam int EXECUTE    = 3;
  localparam int MEMORY     = 4;
  localparam int WRITE_BACK = 5;

  // one-hot stage encodings used as expected-stage states
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_F    = 6'b000001;
  localparam logic [5:0] S_D    = 6'b000010;
  localparam logic [5:0] S_R    = 6'b000100;
  localparam logic [5:0] S_E    = 6'b001000;
  localparam logic [5:0] S_M    = 6'b010000;
  localparam logic [5:0] S_WB   = 6'b100000;

  // mask for instructions that skip READ and MEMORY (also used for illegal)
  localparam logic [5:0] MASK_BASE = 6'b101011;

  // returns {illegal, mask[5:0]} for an opcode
  function automatic logic [6:0] decode_mask(input logic [6:0] op);
    logic [6:0] r;
    r = {1'b0, MASK_BASE};
    case (op)
      7'b0110011, 7'b0010011, 7'b1100011,
      7'b1100111, 7'b1110011:               r = {1'b0, 6'b101111};
      7'b0000011, 7'b0100011:               r = {1'b0, 6'b111111};
      7'b0110111, 7'b0010111,
      7'b1101111, 7'b0001111:               r = {1'b0, MASK_BASE};
      default:                              r = {1'b1, MASK_BASE};
    endcase
    return r;
  endfunction

  logic [5:0]  mask_q,     mask_d;
  logic        illegal_q,  illegal_d;
  logic        seq_err_q,  seq_err_d;
  logic [31:0] instret_q,  instret_d;
  logic [2:0]  last_len_q, last_len_d;
  logic [2:0]  len_q,      len_d;
  logic        started_q,  started_d;
  logic [5:0]  exp_q,      exp_d;

  logic [6:0]  dec;
  logic [2:0]  len_inc;
  logic        retire;

  // decode result and enable mask: live during DECODE so READ can be chosen
  // in the same cycle, latched copy otherwise
  always_comb begin
    dec           = decode_mask(opcode);
    stage_enabled = stage_active[DECODE] ? dec[5:0] : mask_q;
  end

  // next-state logic for mask, sequence checker and length accounting
  always_comb begin
    mask_d    = mask_q;
    illegal_d = illegal_q;
    if (stage_active[DECODE]) begin
      mask_d    = dec[5:0];
      illegal_d = dec[6];
    end

    // expected successor stage; any non-one-hot pattern maps to none
    case (stage_active)
      S_F:     exp_d = S_D;
      S_D:     exp_d = stage_enabled[READ]   ? S_R : S_E;
      S_R:     exp_d = S_E;
      S_E:     exp_d = stage_enabled[MEMORY] ? S_M : S_WB;
      S_M:     exp_d = S_WB;
      S_WB:    exp_d = S_F;
      default: exp_d = S_NONE;
    endcase

    seq_err_d = seq_err_q | (stage_active != exp_q);

    // saturating +1, shared by the counter and the retired length
    len_inc   = (len_q == 3'd7) ? 3'd7 : len_q + 3'd1;
    len_d     = stage_active[FETCH] ? 3'd1 : len_inc;
    started_d = started_q | stage_active[FETCH];

    // a WRITE_BACK before the first FETCH has no instruction behind it
    retire     = stage_active[WRITE_BACK] & started_q;
    instret_d  = retire ? instret_q + 32'd1 : instret_q;
    last_len_d = retire ? len_inc : last_len_q;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= MASK_BASE;
      illegal_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      instret_q  <= 32'd0;
      last_len_q <= 3'd0;
      len_q      <= 3'd0;
      started_q  <= 1'b0;
      exp_q      <= S_WB;
    end else begin
      mask_q     <= mask_d;
      illegal_q  <= illegal_d;
      seq_err_q  <= seq_err_d;
      instret_q  <= instret_d;
      last_len_q <= last_len_d;
      len_q      <= len_d;
      started_q  <= started_d;
      exp_q      <= exp_d;
    end
  end

  assign illegal_insn = illegal_q;
  assign seq_error    = seq_err_q;
  assign instret      = instret_q;
  assign last_len     = last_len_q;

endmodule
